btn_cond: RTL
=============

BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4: number of button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYC, default 250000: consecutive stable samples needed to accept a level change.
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 25000000: held cycles before the first auto-repeat pulse.
REQ-004 The block SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between later auto-repeat pulses.
REQ-005 The block SHALL have port game_clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port game_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port btn_raw_i, input, N_BTN bits: asynchronous buttons, active-high (already inverted upstream).
REQ-008 The block SHALL have port btn_level_o, output, N_BTN bits: debounced level.
REQ-009 The block SHALL have port btn_press_o, output, N_BTN bits: one-cycle press and repeat pulses, feeding game btn_i.
REQ-010 The block SHALL have port btn_release_o, output, N_BTN bits: one-cycle release pulses.

Function
REQ-011 Each btn_raw_i bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL run an independent FSM with states RELEASED, PRESS_CHK, PRESSED and RELEASE_CHK.
REQ-013 The FSM SHALL go RELEASED->PRESS_CHK on synced high, PRESS_CHK->PRESSED after DEBOUNCE_CYC consecutive high samples, and PRESS_CHK->RELEASED on any low sample.
REQ-014 The FSM SHALL go PRESSED->RELEASE_CHK on synced low, RELEASE_CHK->RELEASED after DEBOUNCE_CYC consecutive low samples, and RELEASE_CHK->PRESSED on any high sample.
REQ-015 The stability counter SHALL clear on every CHK-state entry and abort; a bounce SHALL restart the count from 0.
REQ-016 The stability counter SHALL be $clog2(max(DEBOUNCE_CYC,REPEAT_DELAY,REPEAT_PERIOD)+1) bits wide and SHALL never wrap.
REQ-017 For stable raw input, btn_level_o SHALL change exactly DEBOUNCE_CYC+2 cycles after the first clock edge that samples the new raw value.
REQ-018 btn_press_o[i] SHALL be high for exactly one cycle, in the same cycle btn_level_o[i] rises.
REQ-019 btn_release_o[i] SHALL be high for exactly one cycle, in the same cycle btn_level_o[i] falls.
REQ-020 btn_level_o SHALL stay constant during PRESS_CHK and RELEASE_CHK, and aborted checks SHALL emit no pulse.
REQ-021 Channels SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 On game_rst_i high, synchronizer flops, FSMs (RELEASED), counters and all outputs SHALL go to 0 immediately.
REQ-024 Reset mid-check or mid-hold SHALL discard progress and emit no pulse.
REQ-025 A raw input held high through reset SHALL yield btn_press_o DEBOUNCE_CYC+2 cycles after the first post-reset edge.

Configuration
REQ-026 With BTN_AUTOREPEAT_EN defined, a channel held in PRESSED SHALL emit an extra btn_press_o pulse REPEAT_DELAY cycles after entering PRESSED, then one every REPEAT_PERIOD cycles.
REQ-027 With BTN_AUTOREPEAT_EN defined, repeat timing SHALL reset whenever the channel leaves PRESSED, and a RELEASE_CHK bounce back to PRESSED SHALL restart REPEAT_DELAY.
REQ-028 Without BTN_AUTOREPEAT_EN, each accepted press SHALL give exactly one btn_press_o pulse, no repeat logic SHALL exist, and REPEAT_* parameters SHALL be ignored.

Structure
REQ-029 game_pkg SHALL hold the N_BTN default constant and the btn_state_t enum for the four FSM states.
REQ-030 The per-channel synchronizer, FSM, counter and pulse logic SHALL be the sub-module btn_debounce_ch, instantiated N_BTN times in a generate loop.

Verification (DEBOUNCE_CYC=8, REPEAT_DELAY=40, REPEAT_PERIOD=10)
REQ-031 Clean press: raw[0] rises at cycle 0 and holds -> level[0] and one press[0] pulse at cycle 10; other bits stay 0.
REQ-032 Bounce: raw[1] high 5 cycles, low 1, then held high -> no pulse during the bounce; press[1] at 10 cycles after the final rise.
REQ-033 Release: after a clean press, raw[0] falls -> release[0] pulse and level[0]=0 exactly 10 cycles later; a 3-cycle low glitch gives no release.
REQ-034 Simultaneous: raw=4'b1111 at cycle 0 -> press=4'b1111 for one cycle at cycle 10.
REQ-035 Reset: game_rst_i asserted at cycle 6 of a press check -> outputs 0 at once; raw still high -> press 10 cycles after reset release.
REQ-036 Auto-repeat (macro defined): hold raw[2] for 100 cycles -> press[2] at cycles 10, 50, 60, 70, 80, 90, 100; macro undefined -> only at cycle 10.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants, FSM state type and width helper for button conditioning
package game_pkg;

  localparam int N_BTN_DEF = 4;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchronizer, debounce FSM, press/release pulses
// Auto-repeat on held buttons is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

  logic       sync1, sync2;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  // first_q: still waiting out the initial repeat delay rather than a repeat period
  logic first_q, first_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      first_q <= 1'b0;
`endif
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
`ifdef BTN_AUTOREPEAT_EN
      first_q <= first_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    first_d = first_q;
`endif
    case (state_q)
      RELEASED: begin
        if (sync2) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync2) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if ((first_q && cnt_q == RD_LAST) || (!first_q && cnt_q == RP_LAST)) begin
          press_d = 1'b1;
          cnt_d   = '0;
          first_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELEASE_CHK: begin
        if (sync2) begin
          // bounce back to held: repeat timing starts over from the initial delay
          state_d = PRESSED;
          cnt_d   = '0;
`ifdef BTN_AUTOREPEAT_EN
          first_d = 1'b1;
`endif
        end else if (cnt_q == DB_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - N_BTN independent debounced button channels with press/release pulses
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_cond
  import game_pkg::*;
#(
  parameter int N_BTN         = N_BTN_DEF,
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             game_clk_i,
  input  logic             game_rst_i,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk  (game_clk_i),
      .rst  (game_rst_i),
      .raw  (btn_raw_i[i]),
      .level(btn_level_o[i]),
      .press(btn_press_o[i]),
      .rel  (btn_release_o[i])
    );
  end

endmodule
